// File: rtl/feature_map_pool_ctrl.sv
// 2x2 stride-2 signed max-pool sequencer: streams four source pixels per window
// from a 1-cycle-latency BRAM and writes each window maximum to a destination BRAM.
module feature_map_pool_ctrl #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int WIDTH     = 16,
  parameter int SRC_DEPTH = 2048,
  parameter int DST_DEPTH = 2048,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(SRC_DEPTH)-1:0] src_addr,
  input  logic signed [WIDTH-1:0]      src_data,
  output logic                         dst_we,
  output logic [$clog2(DST_DEPTH)-1:0] dst_addr,
  output logic signed [WIDTH-1:0]      dst_data
);

  localparam int SAW = $clog2(SRC_DEPTH);
  localparam int DAW = $clog2(DST_DEPTH);
  localparam int PW  = IMG_W / 2;
  localparam int PH  = IMG_H / 2;
  localparam int NW  = PW * PH;
  localparam int CW  = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [SAW-1:0] SRC_BASE_A = SAW'(SRC_BASE);
  localparam logic [SAW-1:0] IMG_W_A    = SAW'(IMG_W);
  localparam logic [SAW-1:0] ROW_STEP_A = SAW'(2 * IMG_W);
  localparam logic [DAW-1:0] DST_BASE_A = DAW'(DST_BASE);
  localparam logic [DAW-1:0] LAST_IDX   = DAW'(NW - 1);
  localparam logic [CW-1:0]  LAST_COL   = CW'(PW - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               k_q, k_d;
  logic [CW-1:0]            c_q, c_d;
  logic [SAW-1:0]           row_base_q, row_base_d;
  logic [SAW-1:0]           win_base_q, win_base_d;
  logic [DAW-1:0]           out_idx_q, out_idx_d;
  logic signed [WIDTH-1:0]  max_q, max_d;
  logic [SAW-1:0]           src_addr_q, src_addr_d;
  logic [DAW-1:0]           dst_addr_q, dst_addr_d;
  logic signed [WIDTH-1:0]  dst_data_q, dst_data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     dst_we_q, dst_we_d;

  logic [1:0]               k_inc;
  logic [SAW-1:0]           next_win, next_row;
  logic signed [WIDTH-1:0]  candidate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      c_q        <= '0;
      row_base_q <= '0;
      win_base_q <= '0;
      out_idx_q  <= '0;
      max_q      <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dst_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      c_q        <= c_d;
      row_base_q <= row_base_d;
      win_base_q <= win_base_d;
      out_idx_q  <= out_idx_d;
      max_q      <= max_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dst_we_q   <= dst_we_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    c_d        = c_q;
    row_base_d = row_base_q;
    win_base_d = win_base_q;
    out_idx_d  = out_idx_q;
    max_d      = max_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    k_inc      = k_q + 2'd1;
    next_win   = win_base_q + SAW'(2);
    next_row   = row_base_q + ROW_STEP_A;
    candidate  = (src_data > max_q) ? src_data : max_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = READ;
          k_d        = '0;
          c_d        = '0;
          row_base_d = SRC_BASE_A;
          win_base_d = SRC_BASE_A;
          out_idx_d  = '0;
          max_d      = '0;
          src_addr_d = SRC_BASE_A;
        end
      end
      READ: begin
        // src_data lags the address by one cycle, so it carries pixel k-1 here
        if (k_q == 2'd1) begin
          max_d = src_data;
        end else if (k_q != 2'd0) begin
          max_d = candidate;
        end
        if (k_q == 2'd3) begin
          state_d = DRAIN;
        end else begin
          k_d        = k_inc;
          src_addr_d = win_base_q + SAW'(k_inc[0]) + (k_inc[1] ? IMG_W_A : '0);
        end
      end
      DRAIN: begin
        max_d      = candidate;
        dst_data_d = candidate;
        dst_addr_d = DST_BASE_A + out_idx_q;
        state_d    = WRITE;
      end
      WRITE: begin
        out_idx_d = out_idx_q + DAW'(1);
        if (out_idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          k_d     = '0;
          // window origins step by two pixels; a row wrap jumps two image rows
          if (c_q == LAST_COL) begin
            c_d        = '0;
            row_base_d = next_row;
            win_base_d = next_row;
            src_addr_d = next_row;
          end else begin
            c_d        = c_q + CW'(1);
            win_base_d = next_win;
            src_addr_d = next_win;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d   = (state_d == READ) || (state_d == DRAIN) || (state_d == WRITE);
    done_d   = (state_d == DONE);
    dst_we_d = (state_d == WRITE);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign dst_we   = dst_we_q;
  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;

endmodule

// File: tb/tb_feature_map_pool_ctrl.sv
// Randomized bench for feature_map_pool_ctrl: two instances (4x4 with offset bases,
// 5x5 odd-size) checked against a window-max reference computed from the source map.
module tb_feature_map_pool_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic              a_busy, a_done, a_dst_we;
  logic [9:0]        a_src_addr, a_dst_addr;
  logic signed [15:0] a_src_data, a_dst_data;
  logic              b_busy, b_done, b_dst_we;
  logic [9:0]        b_src_addr, b_dst_addr;
  logic signed [15:0] b_src_data, b_dst_data;

  feature_map_pool_ctrl #(
    .IMG_W(4), .IMG_H(4), .WIDTH(16), .SRC_DEPTH(1024), .DST_DEPTH(1024),
    .SRC_BASE(100), .DST_BASE(500)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(a_busy), .done(a_done),
    .src_addr(a_src_addr), .src_data(a_src_data), .dst_we(a_dst_we),
    .dst_addr(a_dst_addr), .dst_data(a_dst_data)
  );

  feature_map_pool_ctrl #(
    .IMG_W(5), .IMG_H(5), .WIDTH(16), .SRC_DEPTH(1024), .DST_DEPTH(1024),
    .SRC_BASE(0), .DST_BASE(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(b_busy), .done(b_done),
    .src_addr(b_src_addr), .src_data(b_src_data), .dst_we(b_dst_we),
    .dst_addr(b_dst_addr), .dst_data(b_dst_data)
  );

  // shared source map, one registered read port per instance
  logic [15:0] src_mem [0:1023];
  always @(posedge clk) begin
    a_src_data <= src_mem[a_src_addr];
    b_src_data <= src_mem[b_src_addr];
  end

  logic              obs_busy, obs_done, obs_we;
  logic [9:0]        obs_src_addr, obs_dst_addr;
  logic signed [15:0] obs_dst_data;
  always_comb begin
    obs_busy     = sel ? b_busy     : a_busy;
    obs_done     = sel ? b_done     : a_done;
    obs_we       = sel ? b_dst_we   : a_dst_we;
    obs_src_addr = sel ? b_src_addr : a_src_addr;
    obs_dst_addr = sel ? b_dst_addr : a_dst_addr;
    obs_dst_data = sel ? b_dst_data : a_dst_data;
  end

  int img_w = 4, img_h = 4, src_base = 100, dst_base = 500;
  int exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // 0: ramp, 1: negative ramp with a -32768, 2: random with extremes, 3: random plus an all -32768 window
  task automatic fill(input int mode);
    int v;
    for (int i = 0; i < img_w * img_h; i++) begin
      case (mode)
        0: v = i;
        1: v = -16 + i;
        default: begin
          case ($urandom_range(0, 3))
            0: v = -32768;
            1: v = 32767;
            default: v = int'($urandom_range(0, 65535));
          endcase
        end
      endcase
      src_mem[src_base + i] = 16'(v);
    end
    if (mode == 1) src_mem[src_base + 5] = 16'h8000;
    if (mode == 3) begin
      src_mem[src_base + 2]         = 16'h8000;
      src_mem[src_base + 3]         = 16'h8000;
      src_mem[src_base + img_w + 2] = 16'h8000;
      src_mem[src_base + img_w + 3] = 16'h8000;
    end
  endtask

  task automatic build_expect();
    int m, v;
    exp_q.delete();
    for (int wr = 0; wr < img_h / 2; wr++) begin
      for (int wc = 0; wc < img_w / 2; wc++) begin
        m = -1000000;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            v = int'($signed(src_mem[src_base + (2 * wr + dy) * img_w + 2 * wc + dx]));
            if (v > m) m = v;
          end
        end
        exp_q.push_back(m);
      end
    end
  endtask

  // caller positions just after a rising edge; start is high in relative cycle 0
  task automatic run_map(input string name, input int pulse_cyc, input int abort_cyc);
    int nw, cyc, wr_n, busy_n, done_cyc, bad_src, off;
    nw = (img_w / 2) * (img_h / 2);
    wr_n = 0; busy_n = 0; done_cyc = -1; bad_src = 0; cyc = 0;
    build_expect();
    start = 1'b1;
    while (cyc <= 6 * nw + 8) begin
      if (cyc == 1) chk("first_src", int'(obs_src_addr), src_base);
      if (obs_busy) begin
        busy_n++;
        off = int'(obs_src_addr) - src_base;
        if (off < 0 || off >= img_w * img_h || (off % img_w) >= 2 * (img_w / 2) ||
            (off / img_w) >= 2 * (img_h / 2))
          bad_src++;
      end
      if (obs_we) begin
        chk("wr_cyc", cyc, 6 * (wr_n + 1));
        chk("wr_addr", int'(obs_dst_addr), dst_base + wr_n);
        chk("wr_data", int'(obs_dst_data), (wr_n < nw) ? exp_q[wr_n] : 0);
        $display("%s win %0d cyc %0d addr %0d data %0d", name, wr_n, cyc,
                 obs_dst_addr, obs_dst_data);
        wr_n++;
      end
      if (cyc == abort_cyc) begin
        chk("busy_pre_rst", int'(obs_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(obs_busy), 0);
        chk("rst_we", int'(obs_we), 0);
        chk("rst_done", int'(obs_done), 0);
        chk("rst_src_addr", int'(obs_src_addr), 0);
        chk("wr_before_rst", wr_n, 1);
        return;
      end
      if (obs_done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == pulse_cyc);
    end
    start = 1'b0;
    chk("done_cyc", done_cyc, 6 * nw + 1);
    chk("wr_count", wr_n, nw);
    chk("busy_cycles", busy_n, 6 * nw);
    chk("bad_src_addr", bad_src, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_busy", int'(a_busy), 0);
    chk("rst_a_done", int'(a_done), 0);
    chk("rst_a_we", int'(a_dst_we), 0);
    chk("rst_a_src", int'(a_src_addr), 0);
    chk("rst_a_dst", int'(a_dst_addr), 0);
    chk("rst_a_data", int'(a_dst_data), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fill(0);
    run_map("ramp+restart", 10, -1);
    @(posedge clk);
    #1;
    chk("idle_gap_busy", int'(obs_busy), 0);
    run_map("back2back", -1, -1);

    @(posedge clk); #1;
    fill(1);
    run_map("negative", -1, -1);

    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      fill((t == 1) ? 3 : 2);
      run_map("random_a", -1, -1);
    end

    @(posedge clk); #1;
    fill(2);
    run_map("abort", -1, 9);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_we", int'(obs_we), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", int'(obs_busy), 0);
    run_map("after_rst", -1, -1);

    @(posedge clk); #1;
    sel = 1'b1;
    img_w = 5; img_h = 5; src_base = 0; dst_base = 0;
    fill(0);
    run_map("odd_ramp", -1, -1);
    @(posedge clk); #1;
    fill(2);
    run_map("odd_random", -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
